// File: rtl/tt_um_islam_ihfaz_nand_engine.sv
// rtl/tt_um_islam_ihfaz_nand_engine.sv - byte NAND engine with result FIFO and pin-level pop handshake
//
// Purpose: captures operand A then operand B from ui_in on rising edges of the
// wr strobe, queues ~(A & B) in a small FIFO, and presents the FIFO head on
// uo_out. A rising edge of the rd strobe pops the head.
//
// Configuration macro: NAND_ENG_PARITY_EN (when defined, uio_out[7] is the
// even parity of uo_out; otherwise it is tied to 0).
//
// Ports:
//   ui_in   [7:0] in   operand byte, sampled on a wr event
//   uo_out  [7:0] out  FIFO head, 8'h00 when empty
//   uio_in  [7:0] in   [0] wr, [1] sel (0=A, 1=B), [2] rd, [3] clr level
//   uio_out [7:0] out  [4] valid, [5] full, [6] err (sticky), [7] parity
//   uio_oe  [7:0] out  constant 8'hF0
//   ena           in   design selected; when low all events and clr are ignored
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset

module tt_um_islam_ihfaz_nand_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_HAVE_A
  } state_e;

  state_e           state_q;
  logic [7:0]       a_q;
  logic             err_q;
  logic             wr_prev_q;
  logic             rd_prev_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       wr_ev, rd_ev, clr, sel;
  logic       empty, full;
  logic       push_try, push_ok, pop_ok, drop;
  logic       parity;
  logic [7:0] result;
  logic       unused_ok;

  assign sel   = uio_in[1];
  assign clr   = ena & uio_in[3];
  // Strobes act only on their rising edge; prev regs track even while ena=0
  // so that re-enabling with a strobe already high does not fire an event.
  assign wr_ev = ena & uio_in[0] & ~wr_prev_q;
  assign rd_ev = ena & uio_in[2] & ~rd_prev_q;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign result = ~(a_q & ui_in);

  // A pop on an empty FIFO is ignored, so a simultaneous push into an empty
  // FIFO simply lands. A pop frees a slot, so a full FIFO still accepts a
  // push on the same edge.
  assign pop_ok   = rd_ev & ~empty;
  assign push_try = wr_ev & sel & (state_q == S_HAVE_A);
  assign push_ok  = push_try & (~full | pop_ok);
  assign drop     = push_try & ~push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= 8'h00;
      err_q     <= 1'b0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_prev_q <= uio_in[0];
      rd_prev_q <= uio_in[2];
      if (clr) begin
        state_q  <= S_IDLE;
        a_q      <= 8'h00;
        err_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_ev) begin
          if (!sel) begin
            a_q     <= ui_in;
            state_q <= S_HAVE_A;
          end else begin
            state_q <= S_IDLE;
          end
        end
        // B without a preceding A, or a push into a full FIFO, flags err.
        if ((wr_ev && sel && state_q == S_IDLE) || drop) err_q <= 1'b1;
        if (push_ok) mem_q[wr_ptr_q] <= result;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end
  end

  assign uo_out = empty ? 8'h00 : mem_q[rd_ptr_q];

`ifdef NAND_ENG_PARITY_EN
  assign parity = ^uo_out;
`else
  assign parity = 1'b0;
`endif

  assign uio_out   = {parity, err_q, full, ~empty, 4'b0000};
  assign uio_oe    = 8'hF0;
  assign unused_ok = &{1'b0, uio_in[7:4]};

endmodule
